apb_master: RTL

Bridge between the CPU data-memory port and the APB peripheral bus. Accepts one single-beat load/store request at a time from the core, decodes the address onto one of five APB slaves (RAM, GPO, GPI, GPIO, UART), runs the APB SETUP/ACCESS sequence, and returns read data plus a completion pulse. Unmapped or unresponsive accesses complete with an error flag, so the core never hangs.

---
 rtl/apb_master.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/apb_master.sv
// Single-beat CPU-to-APB bridge: decodes the core request onto one of five slaves,
// runs SETUP/ACCESS, and returns read data with a one-cycle ready (err on unmapped/timeout).
module apb_master #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        transfer,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  strb_in,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic [31:0] PADDR,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    output logic [2:0]  strb,
    output logic        PENABLE,
    output logic        PSEL0,
    output logic        PSEL1,
    output logic        PSEL2,
    output logic        PSEL3,
    output logic        PSEL4,
    input  logic [31:0] PRDATA0,
    input  logic [31:0] PRDATA1,
    input  logic [31:0] PRDATA2,
    input  logic [31:0] PRDATA3,
    input  logic [31:0] PRDATA4,
    input  logic        PREADY0,
    input  logic        PREADY1,
    input  logic        PREADY2,
    input  logic        PREADY3,
    input  logic        PREADY4
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

    state_e          state_q, state_d;
    logic [2:0]      sel_q, sel_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     paddr_q, paddr_d;
    logic            pwrite_q, pwrite_d;
    logic [31:0]     pwdata_q, pwdata_d;
    logic [2:0]      strb_q, strb_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [19:0] page;
    logic        mapped;
    logic [2:0]  dec_idx;
    logic        sel_ready;
    logic [31:0] sel_rdata;
    logic        timeout_hit;
    logic        bus_active;

    assign page    = addr[31:12];
    assign mapped  = (page >= 20'h10000) && (page <= 20'h10004);
    assign dec_idx = page[2:0];

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = 32'h0;
        case (sel_q)
            3'd0: begin sel_ready = PREADY0; sel_rdata = PRDATA0; end
            3'd1: begin sel_ready = PREADY1; sel_rdata = PRDATA1; end
            3'd2: begin sel_ready = PREADY2; sel_rdata = PRDATA2; end
            3'd3: begin sel_ready = PREADY3; sel_rdata = PRDATA3; end
            3'd4: begin sel_ready = PREADY4; sel_rdata = PRDATA4; end
            default: begin sel_ready = 1'b0; sel_rdata = 32'h0; end
        endcase
    end

    // cnt_q holds completed ACCESS cycles, so the TIMEOUT-th cycle is the last one
    assign timeout_hit = (cnt_q == CntW'(TIMEOUT - 1));

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (transfer) begin
                    state_d = mapped ? StSetup : StDone;
                end
            end
            StSetup:  state_d = StAccess;
            StAccess: begin
                if (sel_ready || timeout_hit) begin
                    state_d = StDone;
                end
            end
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        strb_d   = strb_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (transfer) begin
                    paddr_d  = addr;
                    pwrite_d = write;
                    pwdata_d = wdata;
                    strb_d   = strb_in;
                    sel_d    = mapped ? dec_idx : 3'd7;
                    cnt_d    = '0;
                    rdata_d  = 32'h0;
                    err_d    = !mapped;
                end
            end
            StAccess: begin
                cnt_d = cnt_q + 1'b1;
                // A ready slave wins over a simultaneous timeout
                if (sel_ready) begin
                    rdata_d = pwrite_q ? 32'h0 : sel_rdata;
                    err_d   = 1'b0;
                end else if (timeout_hit) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            sel_q    <= 3'd7;
            cnt_q    <= '0;
            paddr_q  <= 32'h0;
            pwrite_q <= 1'b0;
            pwdata_q <= 32'h0;
            strb_q   <= 3'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            strb_q   <= strb_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        bus_active = (state_q == StSetup) || (state_q == StAccess);
        PENABLE    = (state_q == StAccess);
        ready      = (state_q == StDone);
        err        = (state_q == StDone) && err_q;
        PSEL0      = bus_active && (sel_q == 3'd0);
        PSEL1      = bus_active && (sel_q == 3'd1);
        PSEL2      = bus_active && (sel_q == 3'd2);
        PSEL3      = bus_active && (sel_q == 3'd3);
        PSEL4      = bus_active && (sel_q == 3'd4);
    end

    assign PADDR  = paddr_q;
    assign PWRITE = pwrite_q;
    assign PWDATA = pwdata_q;
    assign strb   = strb_q;
    assign rdata  = rdata_q;

endmodule
